// File: rtl/game_tick_gen.sv
// Multi-channel programmable game-tick generator: per-channel tick strobe, square-wave toggle
// and sticky pending/overrun flags, with free-run, frame-sync, one-shot and stopped modes.
module game_tick_gen #(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = 10000000,
    parameter int unsigned MIN_PERIOD     = 2,
    parameter int unsigned SPEED_STEP     = 1000,
    parameter int unsigned CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              screen_end,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [1:0]        cfg_mode,
    input  logic [NUM_CH-1:0] speedup,
    input  logic [NUM_CH-1:0] ack,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] toggle,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overrun
);

    typedef enum logic [1:0] {
        ModeStop    = 2'b00,
        ModeFree    = 2'b01,
        ModeFrame   = 2'b10,
        ModeOneShot = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] DefPeriod = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] MinPeriod = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] StepSize  = CNT_W'(SPEED_STEP);
    localparam logic [CNT_W-1:0] StepFloor = CNT_W'(MIN_PERIOD + SPEED_STEP);
    localparam logic [CNT_W-1:0] One       = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q    [NUM_CH];
    logic [CNT_W-1:0] cnt_d    [NUM_CH];
    logic [CNT_W-1:0] period_q [NUM_CH];
    logic [CNT_W-1:0] period_d [NUM_CH];
    mode_e            mode_q   [NUM_CH];
    mode_e            mode_d   [NUM_CH];
    logic [NUM_CH-1:0] fire;
    logic [NUM_CH-1:0] at_end;

    always_comb begin
        fire   = '0;
        at_end = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            cnt_d[c]    = cnt_q[c];
            period_d[c] = period_q[c];
            mode_d[c]   = mode_q[c];
            // >= rather than == so a speed-up below the current count wraps on the next edge
            at_end[c]   = (cnt_q[c] >= period_q[c] - One);

            unique case (mode_q[c])
                ModeFree, ModeOneShot: begin
                    if (at_end[c]) begin
                        cnt_d[c] = '0;
                        fire[c]  = 1'b1;
                        if (mode_q[c] == ModeOneShot) mode_d[c] = ModeStop;
                    end else begin
                        cnt_d[c] = cnt_q[c] + One;
                    end
                end
                ModeFrame: begin
                    if (screen_end) begin
                        if (at_end[c]) begin
                            cnt_d[c] = '0;
                            fire[c]  = 1'b1;
                        end else begin
                            cnt_d[c] = cnt_q[c] + One;
                        end
                    end
                end
                default: ;
            endcase

            if (speedup[c] && period_q[c] >= MinPeriod) begin
                period_d[c] = (period_q[c] >= StepFloor) ? period_q[c] - StepSize : MinPeriod;
            end

            if (cfg_we && cfg_ch == CH_W'(c)) begin
                period_d[c] = (cfg_period == '0) ? One : cfg_period;
                mode_d[c]   = mode_e'(cfg_mode);
                cnt_d[c]    = '0;
                fire[c]     = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                cnt_q[c]    <= '0;
                period_q[c] <= DefPeriod;
                mode_q[c]   <= ModeFree;
            end
            tick    <= '0;
            toggle  <= '0;
            pending <= '0;
            overrun <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                cnt_q[c]    <= cnt_d[c];
                period_q[c] <= period_d[c];
                mode_q[c]   <= mode_d[c];
            end
            tick    <= fire;
            toggle  <= toggle ^ fire;
            pending <= fire | (pending & ~ack);
            // a tick landing on an ack'd cycle is not an overrun
            overrun <= (fire & pending & ~ack) | (overrun & ~ack);
        end
    end

endmodule

// File: tb/tb_game_tick_gen.sv
// Directed self-checking bench for game_tick_gen with small periods so every case runs quickly.
module tb_game_tick_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        screen_end = 1'b0;
    logic        cfg_we = 1'b0;
    logic [0:0]  cfg_ch = '0;
    logic [15:0] cfg_period = '0;
    logic [1:0]  cfg_mode = '0;
    logic [1:0]  speedup = '0;
    logic [1:0]  ack = '0;
    logic [1:0]  tick, toggle, pending, overrun;

    int n_checks = 0;
    int n_errors = 0;
    int n;

    game_tick_gen #(
        .NUM_CH        (2),
        .CNT_W         (16),
        .DEFAULT_PERIOD(5),
        .MIN_PERIOD    (3),
        .SPEED_STEP    (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .screen_end(screen_end),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_period(cfg_period),
        .cfg_mode  (cfg_mode),
        .speedup   (speedup),
        .ack       (ack),
        .tick      (tick),
        .toggle    (toggle),
        .pending   (pending),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Steps until tick[ch] is seen; returns the step count, or limit if it never arrives.
    task automatic wait_tick(input int ch, input int limit, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!tick[ch] && cnt < limit);
    endtask

    task automatic cfg(input logic ch, input logic [15:0] p, input logic [1:0] m);
        cfg_we = 1'b1;
        cfg_ch = ch;
        cfg_period = p;
        cfg_mode = m;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        // reset state and default free-run period of 5
        repeat (3) step();
        check("rst_tick", tick, 0);
        check("rst_toggle", toggle, 0);
        check("rst_pending", pending, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step();
            check("t1_tick", tick, (i % 5 == 0) ? 2'b11 : 2'b00);
            if (i % 5 == 0) check("t1_toggle", toggle, (i == 10) ? 2'b00 : 2'b11);
        end

        // one-shot on ch1
        cfg(1'b1, 16'd3, 2'b11);
        check("t2_cfg_tick", tick[1], 0);
        for (int i = 1; i <= 23; i++) begin
            step();
            check("t2_oneshot", tick[1], (i == 3) ? 1 : 0);
        end

        // frame-sync ch0, P=2, frame end every 10 cycles
        cfg(1'b0, 16'd2, 2'b10);
        for (int i = 1; i <= 60; i++) begin
            screen_end = (i % 10 == 0);
            step();
            check("t3_frame", tick[0], (i % 20 == 0) ? 1 : 0);
        end
        screen_end = 1'b0;

        // speed-up: 10 -> 6 -> 3 -> 3
        cfg(1'b0, 16'd10, 2'b01);
        wait_tick(0, 40, n);
        check("t4_gap10", n, 10);
        speedup = 2'b01; step(); speedup = 2'b00;
        wait_tick(0, 40, n);
        check("t4_gap6a", n + 1, 6);
        wait_tick(0, 40, n);
        check("t4_gap6b", n, 6);
        speedup = 2'b01; step(); speedup = 2'b00;
        wait_tick(0, 40, n);
        check("t4_gap3a", n + 1, 3);
        speedup = 2'b01; step(); speedup = 2'b00;
        wait_tick(0, 40, n);
        check("t4_gap3b", n + 1, 3);
        wait_tick(0, 40, n);
        check("t4_gap3c", n, 3);

        // speed-up below the current count wraps on the next edge
        cfg(1'b1, 16'd10, 2'b01);
        repeat (7) step();
        speedup = 2'b10; step(); speedup = 2'b00;
        check("t4_mid_nowrap", tick[1], 0);
        step();
        check("t4_mid_wrap", tick[1], 1);

        // period 0 clamps to 1: tick every cycle
        cfg(1'b1, 16'd0, 2'b01);
        check("t4_p0_cfg", tick[1], 0);
        step();
        check("t4_p0_a", tick[1], 1);
        step();
        check("t4_p0_b", tick[1], 1);

        // pending / overrun
        cfg(1'b0, 16'd4, 2'b00);
        cfg(1'b1, 16'd4, 2'b00);
        ack = 2'b11; step(); ack = 2'b00;
        check("t5_clr_pending", pending, 0);
        check("t5_clr_overrun", overrun, 0);
        cfg(1'b0, 16'd4, 2'b01);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 4) begin
                check("t5_pend1", pending[0], 1);
                check("t5_ovr1", overrun[0], 0);
            end
        end
        check("t5_pend2", pending[0], 1);
        check("t5_ovr2", overrun[0], 1);
        ack = 2'b01; step(); ack = 2'b00;
        check("t5_ack_pend", pending[0], 0);
        check("t5_ack_ovr", overrun[0], 0);
        repeat (3) step();
        check("t5_pend3", pending[0], 1);
        check("t5_ovr3", overrun[0], 0);
        repeat (3) step();
        ack = 2'b01; step(); ack = 2'b00;
        check("t5_coinc_tick", tick[0], 1);
        check("t5_coinc_pend", pending[0], 1);
        check("t5_coinc_ovr", overrun[0], 0);
        repeat (4) step();
        check("t5_pend4", pending[0], 1);
        check("t5_ovr4", overrun[0], 1);

        // cfg_we wins over speedup; reset mid-count
        cfg_we = 1'b1; cfg_ch = 1'b0; cfg_period = 16'd7; cfg_mode = 2'b01; speedup = 2'b01;
        step();
        cfg_we = 1'b0; speedup = 2'b00;
        wait_tick(0, 40, n);
        check("t6_cfg_wins", n, 7);
        repeat (3) step();
        reset = 1'b1; step();
        check("t6_rst_tick", tick, 0);
        check("t6_rst_toggle", toggle, 0);
        check("t6_rst_pending", pending, 0);
        check("t6_rst_overrun", overrun, 0);
        reset = 1'b0;
        wait_tick(0, 40, n);
        check("t6_first_tick", n, 5);
        check("t6_first_tick_ch1", tick[1], 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
